// File: rtl/fll_cfg_ctrl.sv
// FLL configuration sequencer: boot-time programming of the FLL config port,
// lock supervision, software access arbitration and FLL/ref clock selection.
module fll_cfg_ctrl #(
    parameter logic [31:0] CFG1_DEF      = 32'h0000_0000,
    parameter logic [31:0] CFG2_DEF      = 32'h0000_0000,
    parameter int unsigned LOCK_TIMEOUT  = 1024,
    parameter int unsigned SWITCH_CYCLES = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        bypass_i,
    input  logic        sw_req_i,
    input  logic        sw_wrn_i,
    input  logic [1:0]  sw_add_i,
    input  logic [31:0] sw_wdata_i,
    output logic        sw_gnt_o,
    output logic        sw_done_o,
    output logic [31:0] sw_rdata_o,
    output logic        fll_req_o,
    output logic        fll_wrn_o,
    output logic [1:0]  fll_add_o,
    output logic [31:0] fll_data_o,
    input  logic        fll_ack_i,
    input  logic [31:0] fll_rdata_i,
    input  logic        fll_lock_i,
    output logic        clk_sel_o,
    output logic        ready_o,
    output logic        boot_done_o,
    output logic        lock_err_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned STEP_W = 2;
    localparam int unsigned TO_W   = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned SW_W   = $clog2(SWITCH_CYCLES + 1);

    localparam logic [2:0] ST_BOOT      = 3'd0;
    localparam logic [2:0] ST_SEL_OFF   = 3'd1;
    localparam logic [2:0] ST_CFG_REQ   = 3'd2;
    localparam logic [2:0] ST_CFG_REL   = 3'd3;
    localparam logic [2:0] ST_LOCK_WAIT = 3'd4;
    localparam logic [2:0] ST_READY     = 3'd5;

    logic [2:0]        state_q,     state_d;
    logic [STEP_W-1:0] step_q,      step_d;
    logic [TO_W-1:0]   to_cnt_q,    to_cnt_d;
    logic [SW_W-1:0]   sw_cnt_q,    sw_cnt_d;
    logic              freq_wr_q,   freq_wr_d;
    logic              req_q,       req_d;
    logic              wrn_q,       wrn_d;
    logic [ADDR_W-1:0] add_q,       add_d;
    logic [DATA_W-1:0] data_q,      data_d;
    logic [DATA_W-1:0] rcap_q,      rcap_d;
    logic [DATA_W-1:0] sw_rdata_q,  sw_rdata_d;
    logic              gnt_q,       gnt_d;
    logic              done_q,      done_d;
    logic              clk_sel_q,   clk_sel_d;
    logic              ready_q,     ready_d;
    logic              boot_done_q, boot_done_d;
    logic              lock_err_q,  lock_err_d;
    logic              lock_s1_q,   lock_s2_q;

    logic [TO_W-1:0]   to_cnt_inc;
    logic [SW_W-1:0]   sw_cnt_inc;
    logic              sw_freq_wr;

    assign to_cnt_inc = to_cnt_q + TO_W'(1);
    assign sw_cnt_inc = sw_cnt_q + SW_W'(1);
    // Writes to the frequency registers (addr 1/2) require a relock afterwards
    assign sw_freq_wr = !sw_wrn_i && ((sw_add_i == ADDR_W'(1)) || (sw_add_i == ADDR_W'(2)));

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        to_cnt_d    = '0;
        sw_cnt_d    = '0;
        freq_wr_d   = freq_wr_q;
        req_d       = req_q;
        wrn_d       = wrn_q;
        add_d       = add_q;
        data_d      = data_q;
        rcap_d      = rcap_q;
        sw_rdata_d  = sw_rdata_q;
        gnt_d       = 1'b0;
        done_d      = 1'b0;
        clk_sel_d   = clk_sel_q;
        lock_err_d  = lock_err_q;

        case (state_q)
            ST_BOOT: begin
                case (step_q)
                    STEP_W'(0): begin
                        wrn_d   = 1'b0;
                        add_d   = ADDR_W'(1);
                        data_d  = CFG1_DEF;
                        req_d   = 1'b1;
                        state_d = ST_CFG_REQ;
                    end
                    STEP_W'(1): begin
                        wrn_d   = 1'b0;
                        add_d   = ADDR_W'(2);
                        data_d  = CFG2_DEF;
                        req_d   = 1'b1;
                        state_d = ST_CFG_REQ;
                    end
                    default: state_d = ST_LOCK_WAIT;
                endcase
            end

            // Keep the ref clock selected long enough for the mux to settle
            ST_SEL_OFF: begin
                sw_cnt_d = sw_cnt_inc;
                if (sw_cnt_inc == SW_W'(SWITCH_CYCLES)) begin
                    req_d   = 1'b1;
                    state_d = ST_CFG_REQ;
                end
            end

            ST_CFG_REQ: begin
                if (fll_ack_i) begin
                    rcap_d  = fll_rdata_i;
                    req_d   = 1'b0;
                    state_d = ST_CFG_REL;
                end
            end

            ST_CFG_REL: begin
                if (!fll_ack_i) begin
                    if (!boot_done_q) begin
                        step_d  = step_q + STEP_W'(1);
                        state_d = ST_BOOT;
                    end else begin
                        done_d     = 1'b1;
                        sw_rdata_d = rcap_q;
                        state_d    = freq_wr_q ? ST_LOCK_WAIT : ST_READY;
                    end
                end
            end

            ST_LOCK_WAIT: begin
                to_cnt_d = to_cnt_inc;
                if (bypass_i) begin
                    clk_sel_d = 1'b0;
                    state_d   = ST_READY;
                end else if (lock_s2_q) begin
                    clk_sel_d = 1'b1;
                    state_d   = ST_READY;
                end else if (to_cnt_inc == TO_W'(LOCK_TIMEOUT)) begin
                    lock_err_d = 1'b1;
                    clk_sel_d  = 1'b0;
                    state_d    = ST_READY;
                end
            end

            ST_READY: begin
                if (sw_req_i) begin
                    gnt_d     = 1'b1;
                    wrn_d     = sw_wrn_i;
                    add_d     = sw_add_i;
                    data_d    = sw_wdata_i;
                    freq_wr_d = sw_freq_wr;
                    if (sw_freq_wr && clk_sel_q) begin
                        clk_sel_d = 1'b0;
                        state_d   = ST_SEL_OFF;
                    end else begin
                        req_d   = 1'b1;
                        state_d = ST_CFG_REQ;
                    end
                end
            end

            default: state_d = ST_BOOT;
        endcase

        ready_d     = (state_d == ST_READY);
        boot_done_d = boot_done_q | ready_d;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_BOOT;
            step_q      <= '0;
            to_cnt_q    <= '0;
            sw_cnt_q    <= '0;
            freq_wr_q   <= 1'b0;
            req_q       <= 1'b0;
            wrn_q       <= 1'b1;
            add_q       <= '0;
            data_q      <= '0;
            rcap_q      <= '0;
            sw_rdata_q  <= '0;
            gnt_q       <= 1'b0;
            done_q      <= 1'b0;
            clk_sel_q   <= 1'b0;
            ready_q     <= 1'b0;
            boot_done_q <= 1'b0;
            lock_err_q  <= 1'b0;
            lock_s1_q   <= 1'b0;
            lock_s2_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            to_cnt_q    <= to_cnt_d;
            sw_cnt_q    <= sw_cnt_d;
            freq_wr_q   <= freq_wr_d;
            req_q       <= req_d;
            wrn_q       <= wrn_d;
            add_q       <= add_d;
            data_q      <= data_d;
            rcap_q      <= rcap_d;
            sw_rdata_q  <= sw_rdata_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            clk_sel_q   <= clk_sel_d;
            ready_q     <= ready_d;
            boot_done_q <= boot_done_d;
            lock_err_q  <= lock_err_d;
            lock_s1_q   <= fll_lock_i;
            lock_s2_q   <= lock_s1_q;
        end
    end

    assign sw_gnt_o    = gnt_q;
    assign sw_done_o   = done_q;
    assign sw_rdata_o  = sw_rdata_q;
    assign fll_req_o   = req_q;
    assign fll_wrn_o   = wrn_q;
    assign fll_add_o   = add_q;
    assign fll_data_o  = data_q;
    assign clk_sel_o   = clk_sel_q;
    assign ready_o     = ready_q;
    assign boot_done_o = boot_done_q;
    assign lock_err_o  = lock_err_q;

endmodule

// File: tb/tb_fll_cfg_ctrl.sv
// Scoreboard bench for fll_cfg_ctrl: expected FLL requests and sw completions
// are queued by the stimulus and consumed by a negedge monitor.
`timescale 1ns/1ps
module tb_fll_cfg_ctrl;

    localparam logic [31:0] CFG1 = 32'h0000_1234;
    localparam logic [31:0] CFG2 = 32'h0000_5678;
    localparam int unsigned TO   = 16;
    localparam int unsigned SWC  = 4;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        bypass_i = 1'b0;
    logic        sw_req_i = 1'b0;
    logic        sw_wrn_i = 1'b1;
    logic [1:0]  sw_add_i = 2'd0;
    logic [31:0] sw_wdata_i = 32'h0;
    logic        sw_gnt_o, sw_done_o;
    logic [31:0] sw_rdata_o;
    logic        fll_req_o, fll_wrn_o;
    logic [1:0]  fll_add_o;
    logic [31:0] fll_data_o;
    logic        fll_ack_i;
    logic [31:0] fll_rdata_i = 32'h0;
    logic        fll_lock_i = 1'b0;
    logic        clk_sel_o, ready_o, boot_done_o, lock_err_o;

    fll_cfg_ctrl #(
        .CFG1_DEF(CFG1), .CFG2_DEF(CFG2), .LOCK_TIMEOUT(TO), .SWITCH_CYCLES(SWC)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .bypass_i(bypass_i),
        .sw_req_i(sw_req_i), .sw_wrn_i(sw_wrn_i), .sw_add_i(sw_add_i), .sw_wdata_i(sw_wdata_i),
        .sw_gnt_o(sw_gnt_o), .sw_done_o(sw_done_o), .sw_rdata_o(sw_rdata_o),
        .fll_req_o(fll_req_o), .fll_wrn_o(fll_wrn_o), .fll_add_o(fll_add_o), .fll_data_o(fll_data_o),
        .fll_ack_i(fll_ack_i), .fll_rdata_i(fll_rdata_i), .fll_lock_i(fll_lock_i),
        .clk_sel_o(clk_sel_o), .ready_o(ready_o), .boot_done_o(boot_done_o), .lock_err_o(lock_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        wrn;
        logic [1:0]  add;
        logic [31:0] data;
    } req_t;

    req_t        exp_req_q[$];
    logic [31:0] exp_done_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FLL config port model: combinational loopback or delayed ack with hold
    bit   loopback  = 1'b1;
    int   ack_dly   = 0;
    int   ack_hold  = 0;
    logic ack_m     = 1'b0;
    assign fll_ack_i = loopback ? fll_req_o : ack_m;

    initial begin
        int dc, hc;
        dc = 0;
        hc = 0;
        forever begin
            @(negedge clk_i);
            if (ack_m) begin
                if (!fll_req_o) begin
                    hc++;
                    if (hc >= ack_hold) begin
                        ack_m = 1'b0;
                        hc    = 0;
                    end
                end
            end else if (fll_req_o && !loopback) begin
                dc++;
                if (dc >= ack_dly) begin
                    ack_m = 1'b1;
                    dc    = 0;
                end
            end else begin
                dc = 0;
            end
        end
    end

    // Monitor: checks each FLL request and each sw completion against the queues
    logic prev_req = 1'b0;
    logic prev_sel = 1'b0;
    req_t cur, e;
    int   req_len = 0;
    bit   stable = 1'b1;
    int   low_run = 0;
    int   low_at_req = 0;
    bit   sel_dropped = 1'b0;
    logic [31:0] ed;

    initial begin
        forever begin
            @(negedge clk_i);
            if (!rstn_i) begin
                prev_req = 1'b0;
                prev_sel = 1'b0;
                req_len  = 0;
                low_run  = 0;
            end else begin
                if (fll_req_o && !prev_req) begin
                    low_at_req = low_run;
                    if (!loopback) check("ack_low_at_req", 64'(fll_ack_i), 64'd0);
                    if (exp_req_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_req: got add=%0h data=%0h wrn=%0b, required none",
                                 fll_add_o, fll_data_o, fll_wrn_o);
                    end else begin
                        e = exp_req_q.pop_front();
                        check("req_wrn",  64'(fll_wrn_o),  64'(e.wrn));
                        check("req_add",  64'(fll_add_o),  64'(e.add));
                        check("req_data", 64'(fll_data_o), 64'(e.data));
                    end
                    cur     = '{fll_wrn_o, fll_add_o, fll_data_o};
                    req_len = 0;
                    stable  = 1'b1;
                end
                if (fll_req_o) begin
                    req_len++;
                    if ({fll_wrn_o, fll_add_o, fll_data_o} != cur) stable = 1'b0;
                end
                if (!fll_req_o && prev_req) begin
                    check("req_fields_stable", 64'(stable), 64'd1);
                    if (!loopback) check("req_len_ge_ack_dly", 64'(req_len >= ack_dly), 64'd1);
                end
                if (sw_done_o) begin
                    if (exp_done_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_done: got rdata=%0h, required none", sw_rdata_o);
                    end else begin
                        ed = exp_done_q.pop_front();
                        check("done_rdata", 64'(sw_rdata_o), 64'(ed));
                    end
                end
                if (prev_sel && !clk_sel_o) sel_dropped = 1'b1;
                low_run  = clk_sel_o ? 0 : low_run + 1;
                prev_req = fll_req_o;
                prev_sel = clk_sel_o;
            end
        end
    end

    function automatic bit sig_val(input int which);
        case (which)
            0:       return ready_o;
            1:       return sw_gnt_o;
            2:       return sw_done_o;
            3:       return clk_sel_o;
            5:       return fll_req_o && (fll_add_o == 2'd2);
            6:       return !fll_req_o;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int which, input int budget, input string name);
        int n;
        n = 0;
        forever begin
            @(negedge clk_i);
            if (sig_val(which)) break;
            n++;
            if (n >= budget) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout_%s: event absent after %0d cycles, required within budget", name, budget);
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        #1 rstn_i = 1'b0;
        #1;
        check("rst_clk_sel",   64'(clk_sel_o),   64'd0);
        check("rst_req",       64'(fll_req_o),   64'd0);
        check("rst_wrn",       64'(fll_wrn_o),   64'd1);
        check("rst_add_data",  64'({fll_add_o, fll_data_o}), 64'd0);
        check("rst_ready",     64'(ready_o),     64'd0);
        check("rst_boot_done", 64'(boot_done_o), 64'd0);
        check("rst_lock_err",  64'(lock_err_o),  64'd0);
        check("rst_sw_out",    64'({sw_gnt_o, sw_done_o, sw_rdata_o}), 64'd0);
        repeat (2) @(negedge clk_i);
    endtask

    task automatic push_boot();
        exp_req_q.push_back('{1'b0, 2'd1, CFG1});
        exp_req_q.push_back('{1'b0, 2'd2, CFG2});
    endtask

    task automatic sw_access(input logic wrn, input logic [1:0] add, input logic [31:0] wd, input int budget);
        sw_wrn_i   = wrn;
        sw_add_i   = add;
        sw_wdata_i = wd;
        sw_req_i   = 1'b1;
        wait_sig(1, budget, "gnt");
        sw_req_i   = 1'b0;
    endtask

    initial begin
        int n;
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Boot with loopback ack; lock arrives 10 cycles after reset release
        apply_reset();
        push_boot();
        @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (10) @(negedge clk_i);
        fll_lock_i = 1'b1;
        wait_sig(0, 100, "boot_ready");
        check("boot_clk_sel",   64'(clk_sel_o),   64'd1);
        check("boot_done",      64'(boot_done_o), 64'd1);
        check("boot_lock_err",  64'(lock_err_o),  64'd0);

        // Plain read: clock selection must not move
        fll_rdata_i = 32'h0000_CAFE;
        exp_req_q.push_back('{1'b1, 2'd0, 32'h0});
        exp_done_q.push_back(32'h0000_CAFE);
        sel_dropped = 1'b0;
        sw_access(1'b1, 2'd0, 32'h0, 20);
        wait_sig(2, 20, "read_done");
        check("read_ready",       64'(ready_o),     64'd1);
        check("read_sel_dropped", 64'(sel_dropped), 64'd0);

        // Frequency write while on FLL clock: ref clock for SWC cycles, then relock
        fll_rdata_i = 32'h0;
        exp_req_q.push_back('{1'b0, 2'd1, 32'h55});
        exp_done_q.push_back(32'h0);
        sw_access(1'b0, 2'd1, 32'h55, 20);
        check("wr1_sel_off_at_gnt", 64'(clk_sel_o), 64'd0);
        wait_sig(2, 40, "wr1_done");
        check("wr1_ref_cycles", 64'(low_at_req), 64'(SWC));
        wait_sig(3, 40, "wr1_relock");
        check("wr1_ready_after_relock", 64'(ready_o), 64'd1);

        // Lock loss in READY is ignored
        fll_lock_i = 1'b0;
        repeat (6) @(negedge clk_i);
        check("lockloss_ready",   64'(ready_o),   64'd1);
        check("lockloss_clk_sel", 64'(clk_sel_o), 64'd1);

        // No lock: timeout exactly TO cycles after LOCK_WAIT entry
        apply_reset();
        push_boot();
        rstn_i = 1'b1;
        wait_sig(5, 50, "to_boot_req2");
        wait_sig(6, 50, "to_boot_req2_fall");
        n = 0;
        while (n < 100) begin
            @(negedge clk_i);
            n++;
            if (lock_err_o) break;
        end
        check("timeout_cycles",  64'(n),          64'(TO + 2));
        check("timeout_clk_sel", 64'(clk_sel_o),  64'd0);
        check("timeout_ready",   64'(ready_o),    64'd1);

        // Frequency write on ref clock: no switch delay, then lock re-attempt
        exp_req_q.push_back('{1'b0, 2'd2, 32'h77});
        exp_done_q.push_back(32'h0);
        sw_access(1'b0, 2'd2, 32'h77, 20);
        wait_sig(2, 20, "wr2_done");
        check("wr2_relock_wait", 64'(ready_o), 64'd0);
        fll_lock_i = 1'b1;
        wait_sig(3, 40, "wr2_lock");
        check("wr2_lock_err_sticky", 64'(lock_err_o), 64'd1);

        // Slow FLL: ack after 5 cycles, held 3; sw request pending during boot
        apply_reset();
        loopback    = 1'b0;
        ack_dly     = 5;
        ack_hold    = 3;
        fll_rdata_i = 32'h0000_BEEF;
        push_boot();
        exp_req_q.push_back('{1'b1, 2'd3, 32'h0});
        exp_done_q.push_back(32'h0000_BEEF);
        rstn_i = 1'b1;
        sw_access(1'b1, 2'd3, 32'h0, 300);
        check("slow_gnt_after_boot", 64'(boot_done_o), 64'd1);
        wait_sig(2, 60, "slow_done");
        check("slow_clk_sel", 64'(clk_sel_o), 64'd1);

        // Reset in the middle of the second boot write, then clean restart
        apply_reset();
        ack_dly = 20;
        push_boot();
        rstn_i = 1'b1;
        wait_sig(5, 100, "mid_req2");
        apply_reset();
        loopback = 1'b1;
        ack_dly  = 0;
        ack_hold = 0;
        push_boot();
        rstn_i = 1'b1;
        wait_sig(0, 100, "restart_ready");
        check("restart_clk_sel",   64'(clk_sel_o),   64'd1);
        check("restart_boot_done", 64'(boot_done_o), 64'd1);
        repeat (3) @(negedge clk_i);
        check("req_queue_drained",  64'(exp_req_q.size()),  64'd0);
        check("done_queue_drained", 64'(exp_done_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
